store_narrow: RTL and testbench
===============================

STORE_NARROW -- requirements
Module: store_narrow

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum MemAck wait in cycles (range 2..255).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Start, input, 1 bit: store request, sampled only in IDLE.
REQ-005 The block SHALL have port StoreSel, input, 2 bits: 00 sw, 01 sh, 10 sb, 11 reserved.
REQ-006 The block SHALL have port Addr, input, 32 bits: byte address of the store.
REQ-007 The block SHALL have port WriteData, input, 32 bits: register data; low byte/half/word is stored.
REQ-008 The block SHALL have port MemReq, output, 1 bit: memory write request.
REQ-009 The block SHALL have port MemAddr, output, 32 bits: word-aligned address, {Addr[31:2],2'b00}.
REQ-010 The block SHALL have port MemWData, output, 32 bits: lane-replicated write data.
REQ-011 The block SHALL have port MemBE, output, 4 bits: byte enables; bit i enables byte lane i (lane 0 = bits 7:0).
REQ-012 The block SHALL have port MemAck, input, 1 bit: memory accepted the write.
REQ-013 The block SHALL have port Busy, output, 1 bit: high in every state other than IDLE.
REQ-014 The block SHALL have port Done, output, 1 bit: one-cycle pulse on successful completion.
REQ-015 The block SHALL have port AddrErr, output, 1 bit: one-cycle pulse on misaligned address or reserved StoreSel.
REQ-016 The block SHALL have port Timeout, output, 1 bit: one-cycle pulse when MemAck does not arrive within TIMEOUT cycles.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, DONE and ERR.
REQ-018 On Start in IDLE at edge N, the block SHALL capture Addr, StoreSel and WriteData, and enter REQ (legal store) or ERR (illegal store) at edge N.
REQ-019 Illegal stores SHALL be: sh with Addr[0]=1; sw with Addr[1:0]!=00; StoreSel=11.
REQ-020 In REQ, MemReq SHALL be 1 and MemAddr, MemWData and MemBE SHALL stay stable from the captured values until MemAck is sampled high.
REQ-021 sb SHALL drive MemWData={4{WriteData[7:0]}} and MemBE=4'b0001<<Addr[1:0].
REQ-022 sh SHALL drive MemWData={2{WriteData[15:0]}}, MemBE=0011 when Addr[1]=0, and MemBE=1100 when Addr[1]=1.
REQ-023 sw SHALL drive MemWData=WriteData and MemBE=1111.
REQ-024 When MemAck is sampled 1 in REQ, the FSM SHALL enter DONE; DONE SHALL assert Done=1 for exactly one cycle and then return to IDLE.
REQ-025 An 8-bit wait counter SHALL clear on entry to REQ and increment on each REQ cycle with MemAck=0.
REQ-026 When the counter reaches TIMEOUT-1 with MemAck=0, the FSM SHALL enter ERR with Timeout flagged.
REQ-027 ERR SHALL pulse AddrErr or Timeout (exactly one of them) for one cycle, keep MemReq=0, and then return to IDLE.
REQ-028 MemAck sampled 1 in the same cycle the counter reaches TIMEOUT-1 SHALL count as success: Done, no Timeout.
REQ-029 Start while Busy=1 SHALL be ignored with no queuing; MemAck outside REQ SHALL be ignored.
REQ-030 Minimum latency SHALL be: Start at edge N, MemReq high in cycle N..N+1, MemAck at edge N+1, Done high in cycle N+1..N+2, IDLE at edge N+2.
REQ-031 Outside REQ, MemReq SHALL be 0, MemBE SHALL be 0000, and MemWData and MemAddr SHALL hold their last values.

Reset
REQ-032 Reset=1 at an edge SHALL force IDLE, clear the counter and set MemReq=0, MemBE=0000, MemAddr=0, MemWData=0, Busy=0, Done=0, AddrErr=0 and Timeout=0, overriding any in-flight transaction.
REQ-033 A transaction aborted by reset SHALL produce no Done, AddrErr or Timeout pulse.

Structure
REQ-034 A shared package store_pkg SHALL hold the StoreSel encodings (SEL_SW, SEL_SH, SEL_SB, SEL_RSV) and the FSM state type.
REQ-035 Lane placement and legality checking SHALL be a combinational sub-module store_lane_align (inputs StoreSel, Addr[1:0], WriteData; outputs wdata, be, illegal), instantiated once.

Verification
REQ-036 The bench SHALL cover: sb, Addr=0x1003, WriteData=0x123456AB, MemAck one cycle later -> MemAddr=0x1000, MemWData=0xABABABAB, MemBE=1000, Done pulse once.
REQ-037 The bench SHALL cover: sh, Addr=0x2002, WriteData=0xFFFF8001, MemAck after 3 wait cycles -> MemWData=0x80018001, MemBE=1100, all outputs stable while waiting, Done pulse.
REQ-038 The bench SHALL cover: sw, Addr=0x0006 -> ERR, AddrErr for one cycle, MemReq never 1; repeat with StoreSel=11 and Addr=0 -> AddrErr.
REQ-039 The bench SHALL cover: TIMEOUT=4, sw, Addr=0x10, MemAck held 0 -> MemReq high for 4 cycles, then Timeout pulse; a second run with MemAck on the 4th cycle -> Done, no Timeout.
REQ-040 The bench SHALL cover: Reset=1 in the 2nd REQ cycle -> MemReq=0 and Busy=0 at the next edge, no Done, AddrErr or Timeout pulse; a new Start is accepted afterwards.
REQ-041 The bench SHALL cover: Start pulsed during REQ with different data -> ignored, the original transaction completes unchanged.

Source files
------------

// File: rtl/store_pkg.sv
// Shared definitions for the narrow-store unit.
// Holds the StoreSel encodings and the store FSM state type.
package store_pkg;

    // StoreSel encodings: word, halfword, byte, reserved
    typedef enum logic [1:0] {
        SEL_SW  = 2'b00,
        SEL_SH  = 2'b01,
        SEL_SB  = 2'b10,
        SEL_RSV = 2'b11
    } storeSel_e;

    // Store FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } state_e;

endpackage : store_pkg

// File: rtl/store_lane_align.sv
// Combinational lane placement and legality check for narrow stores.
// Ports:
//   StoreSel  - store width select (sw/sh/sb/reserved)
//   Addr      - low two bits of the byte address
//   WriteData - register data; the low byte/half/word is stored
//   wdata     - lane-replicated write data
//   be        - byte enables, bit i enables lane i (lane 0 = bits 7:0)
//   illegal   - misaligned address or reserved StoreSel
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]  StoreSel,
    input  logic [1:0]  Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        illegal
);

    // Replicate the stored quantity across lanes and pick byte enables
    always_comb begin
        wdata   = 32'h0000_0000;
        be      = 4'b0000;
        illegal = 1'b0;
        case (StoreSel)
            SEL_SW: begin
                wdata   = WriteData;
                be      = 4'b1111;
                illegal = (Addr != 2'b00);
            end
            SEL_SH: begin
                wdata   = {2{WriteData[15:0]}};
                be      = Addr[1] ? 4'b1100 : 4'b0011;
                illegal = Addr[0];
            end
            SEL_SB: begin
                wdata   = {4{WriteData[7:0]}};
                be      = 4'b0001 << Addr;
                illegal = 1'b0;
            end
            default: begin
                // Reserved encoding: no lanes, always rejected
                wdata   = 32'h0000_0000;
                be      = 4'b0000;
                illegal = 1'b1;
            end
        endcase
    end

endmodule : store_lane_align

// File: rtl/store_narrow.sv
// Narrow store unit: turns a sw/sh/sb request into a single word-aligned
// memory write with byte enables, with alignment checking and an ack timeout.
// Ports:
//   CLK, Reset           - clock, synchronous active-high reset
//   Start                - store request, sampled only when idle
//   StoreSel, Addr,
//   WriteData            - store width, byte address, register data
//   MemReq, MemAddr,
//   MemWData, MemBE      - memory write request and its payload
//   MemAck               - memory accepted the write
//   Busy                 - high whenever not idle
//   Done, AddrErr,
//   Timeout              - one-cycle completion / error pulses
// All outputs are registered.
module store_narrow
    import store_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  StoreSel,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemBE,
    input  logic        MemAck,
    output logic        Busy,
    output logic        Done,
    output logic        AddrErr,
    output logic        Timeout
);

    // Last counter value before the wait is declared expired
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e      state_r;
    state_e      nextState_s;
    logic [7:0]  waitCnt_r;
    logic [7:0]  waitCntNext_s;

    logic [31:0] alignWData_s;
    logic [3:0]  alignBe_s;
    logic        alignIllegal_s;

    logic        memReqNext_s;
    logic [31:0] memAddrNext_s;
    logic [31:0] memWDataNext_s;
    logic [3:0]  memBeNext_s;
    logic        doneNext_s;
    logic        addrErrNext_s;
    logic        timeoutNext_s;

    store_lane_align uAlign (
        .StoreSel  (StoreSel),
        .Addr      (Addr[1:0]),
        .WriteData (WriteData),
        .wdata     (alignWData_s),
        .be        (alignBe_s),
        .illegal   (alignIllegal_s)
    );

    // Next-state and next-output logic; outputs are computed for the
    // coming state so they can be registered without a cycle of lag
    always_comb begin
        nextState_s    = state_r;
        waitCntNext_s  = waitCnt_r;
        memReqNext_s   = 1'b0;
        memBeNext_s    = 4'b0000;
        memAddrNext_s  = MemAddr;
        memWDataNext_s = MemWData;
        doneNext_s     = 1'b0;
        addrErrNext_s  = 1'b0;
        timeoutNext_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    if (alignIllegal_s) begin
                        // Address/data outputs keep their old values on error
                        nextState_s   = ERR;
                        addrErrNext_s = 1'b1;
                    end else begin
                        nextState_s    = REQ;
                        waitCntNext_s  = 8'd0;
                        memReqNext_s   = 1'b1;
                        memBeNext_s    = alignBe_s;
                        memAddrNext_s  = {Addr[31:2], 2'b00};
                        memWDataNext_s = alignWData_s;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            REQ: begin
                // An ack on the last allowed cycle still wins over timeout
                if (MemAck) begin
                    nextState_s = DONE;
                    doneNext_s  = 1'b1;
                end else if (waitCnt_r == WAIT_LAST) begin
                    nextState_s   = ERR;
                    timeoutNext_s = 1'b1;
                end else begin
                    nextState_s   = REQ;
                    waitCntNext_s = waitCnt_r + 8'd1;
                    memReqNext_s  = 1'b1;
                    memBeNext_s   = MemBE;
                end
            end
            DONE: begin
                nextState_s = IDLE;
            end
            ERR: begin
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs with synchronous reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r   <= IDLE;
            waitCnt_r <= 8'd0;
            MemReq    <= 1'b0;
            MemAddr   <= 32'h0000_0000;
            MemWData  <= 32'h0000_0000;
            MemBE     <= 4'b0000;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            AddrErr   <= 1'b0;
            Timeout   <= 1'b0;
        end else begin
            state_r   <= nextState_s;
            waitCnt_r <= waitCntNext_s;
            MemReq    <= memReqNext_s;
            MemAddr   <= memAddrNext_s;
            MemWData  <= memWDataNext_s;
            MemBE     <= memBeNext_s;
            Busy      <= (nextState_s != IDLE);
            Done      <= doneNext_s;
            AddrErr   <= addrErrNext_s;
            Timeout   <= timeoutNext_s;
        end
    end

endmodule : store_narrow

// File: tb/tb_store_narrow.sv
// Directed self-checking bench for store_narrow (TIMEOUT = 4).
module tb_store_narrow;

    logic        CLK;
    logic        Reset;
    logic        Start;
    logic [1:0]  StoreSel;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBE;
    logic        MemAck;
    logic        Busy;
    logic        Done;
    logic        AddrErr;
    logic        Timeout;

    int checks = 0;
    int errors = 0;

    store_narrow #(.TIMEOUT(4)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Start     (Start),
        .StoreSel  (StoreSel),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemReq    (MemReq),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemBE     (MemBE),
        .MemAck    (MemAck),
        .Busy      (Busy),
        .Done      (Done),
        .AddrErr   (AddrErr),
        .Timeout   (Timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge; outputs settle and inputs may change 1 time unit later
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulses all quiet
    task automatic chkQuiet(input string tag);
        chk1({tag, ".Done"}, Done, 1'b0);
        chk1({tag, ".AddrErr"}, AddrErr, 1'b0);
        chk1({tag, ".Timeout"}, Timeout, 1'b0);
    endtask

    task automatic startStore(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] wd);
        Start     = 1'b1;
        StoreSel  = sel;
        Addr      = a;
        WriteData = wd;
        tick();
        Start     = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; StoreSel = 2'b00;
        Addr = 32'h0; WriteData = 32'h0; MemAck = 1'b0;
        repeat (2) tick();

        // Reset state
        chk1("rst.MemReq", MemReq, 1'b0);
        chk4("rst.MemBE", MemBE, 4'b0000);
        chk32("rst.MemAddr", MemAddr, 32'h0);
        chk32("rst.MemWData", MemWData, 32'h0);
        chk1("rst.Busy", Busy, 1'b0);
        chkQuiet("rst");
        Reset = 1'b0;
        tick();

        // MemAck while idle is ignored
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk1("idleAck.Busy", Busy, 1'b0);
        chkQuiet("idleAck");

        // sb at 0x1003, ack one cycle later
        startStore(2'b10, 32'h0000_1003, 32'h1234_56AB);
        chk1("sb.MemReq", MemReq, 1'b1);
        chk32("sb.MemAddr", MemAddr, 32'h0000_1000);
        chk32("sb.MemWData", MemWData, 32'hABAB_ABAB);
        chk4("sb.MemBE", MemBE, 4'b1000);
        chk1("sb.Busy", Busy, 1'b1);
        chk1("sb.DoneEarly", Done, 1'b0);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk1("sb.Done", Done, 1'b1);
        chk1("sb.MemReqOff", MemReq, 1'b0);
        chk4("sb.MemBEOff", MemBE, 4'b0000);
        chk32("sb.MemAddrHold", MemAddr, 32'h0000_1000);
        chk32("sb.MemWDataHold", MemWData, 32'hABAB_ABAB);
        chk1("sb.BusyDone", Busy, 1'b1);
        tick();
        chk1("sb.DoneOnce", Done, 1'b0);
        chk1("sb.Idle", Busy, 1'b0);

        // sh at 0x2002, three wait cycles then ack
        startStore(2'b01, 32'h0000_2002, 32'hFFFF_8001);
        for (int i = 0; i < 3; i++) begin
            chk1("sh.MemReq", MemReq, 1'b1);
            chk32("sh.MemAddr", MemAddr, 32'h0000_2000);
            chk32("sh.MemWData", MemWData, 32'h8001_8001);
            chk4("sh.MemBE", MemBE, 4'b1100);
            chkQuiet("sh.wait");
            tick();
        end
        chk1("sh.MemReq4", MemReq, 1'b1);
        chk4("sh.MemBE4", MemBE, 4'b1100);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk1("sh.Done", Done, 1'b1);
        chk1("sh.NoTimeout", Timeout, 1'b0);
        tick();
        chk1("sh.Idle", Busy, 1'b0);
        chk1("sh.DoneOnce", Done, 1'b0);

        // Misaligned sw
        startStore(2'b00, 32'h0000_0006, 32'h5555_AAAA);
        chk1("swMis.AddrErr", AddrErr, 1'b1);
        chk1("swMis.MemReq", MemReq, 1'b0);
        chk4("swMis.MemBE", MemBE, 4'b0000);
        chk1("swMis.Busy", Busy, 1'b1);
        chk32("swMis.MemAddrHold", MemAddr, 32'h0000_2000);
        chk1("swMis.Timeout", Timeout, 1'b0);
        tick();
        chk1("swMis.AddrErrOnce", AddrErr, 1'b0);
        chk1("swMis.MemReqAfter", MemReq, 1'b0);
        chk1("swMis.Idle", Busy, 1'b0);

        // Reserved StoreSel
        startStore(2'b11, 32'h0000_0000, 32'h1111_2222);
        chk1("rsv.AddrErr", AddrErr, 1'b1);
        chk1("rsv.MemReq", MemReq, 1'b0);
        tick();
        chk1("rsv.AddrErrOnce", AddrErr, 1'b0);

        // Odd sh
        startStore(2'b01, 32'h0000_0001, 32'h0000_1234);
        chk1("shOdd.AddrErr", AddrErr, 1'b1);
        chk1("shOdd.MemReq", MemReq, 1'b0);
        tick();

        // sw timeout: four request cycles, then Timeout
        startStore(2'b00, 32'h0000_0010, 32'hCAFE_F00D);
        for (int i = 0; i < 4; i++) begin
            chk1("to.MemReq", MemReq, 1'b1);
            chk4("to.MemBE", MemBE, 4'b1111);
            chk32("to.MemWData", MemWData, 32'hCAFE_F00D);
            chk32("to.MemAddr", MemAddr, 32'h0000_0010);
            tick();
        end
        chk1("to.Timeout", Timeout, 1'b1);
        chk1("to.MemReqOff", MemReq, 1'b0);
        chk1("to.Done", Done, 1'b0);
        chk1("to.AddrErr", AddrErr, 1'b0);
        tick();
        chk1("to.TimeoutOnce", Timeout, 1'b0);
        chk1("to.Idle", Busy, 1'b0);

        // sw with ack on the 4th request cycle: success
        startStore(2'b00, 32'h0000_0010, 32'hCAFE_F00D);
        repeat (3) tick();
        chk1("to2.MemReq4", MemReq, 1'b1);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk1("to2.Done", Done, 1'b1);
        chk1("to2.Timeout", Timeout, 1'b0);
        tick();

        // Reset in the second request cycle
        startStore(2'b00, 32'h0000_0020, 32'h1111_1111);
        tick();
        chk1("rstMid.MemReqBefore", MemReq, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk1("rstMid.MemReq", MemReq, 1'b0);
        chk1("rstMid.Busy", Busy, 1'b0);
        chk4("rstMid.MemBE", MemBE, 4'b0000);
        chk32("rstMid.MemAddr", MemAddr, 32'h0);
        chkQuiet("rstMid");
        for (int i = 0; i < 5; i++) begin
            tick();
            chkQuiet("rstMid.after");
            chk1("rstMid.BusyAfter", Busy, 1'b0);
        end
        startStore(2'b10, 32'h0000_0031, 32'h0000_00EE);
        chk1("rstNew.MemReq", MemReq, 1'b1);
        chk4("rstNew.MemBE", MemBE, 4'b0010);
        chk32("rstNew.MemWData", MemWData, 32'hEEEE_EEEE);
        chk32("rstNew.MemAddr", MemAddr, 32'h0000_0030);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk1("rstNew.Done", Done, 1'b1);
        tick();

        // Start during REQ and DONE is ignored
        startStore(2'b01, 32'h0000_0040, 32'h0000_BEEF);
        Start = 1'b1; StoreSel = 2'b10; Addr = 32'h0000_0055; WriteData = 32'h0000_0077;
        tick();
        chk32("ign.MemAddr", MemAddr, 32'h0000_0040);
        chk32("ign.MemWData", MemWData, 32'hBEEF_BEEF);
        chk4("ign.MemBE", MemBE, 4'b0011);
        chk1("ign.MemReq", MemReq, 1'b1);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk1("ign.Done", Done, 1'b1);
        chk32("ign.MemAddrHold", MemAddr, 32'h0000_0040);
        tick();
        Start = 1'b0;
        chk1("ign.Idle", Busy, 1'b0);
        chk1("ign.MemReqOff", MemReq, 1'b0);
        chk32("ign.MemWDataHold", MemWData, 32'hBEEF_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_store_narrow
